bin2bcd_seq: RTL



---
 rtl/bin2bcd_seq.sv | 115 +++++++++++
 1 files changed

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per cycle.
// Optional registered overflow flag (result > 99) enabled by BIN2BCD_OVF_EN.
module bin2bcd_seq #(
    parameter int unsigned W  = 8,
    parameter int unsigned ND = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [W-1:0]    bin,
    output logic            busy,
    output logic            done,
    output logic [4*ND-1:0] bcd
`ifdef BIN2BCD_OVF_EN
    ,
    output logic            ovf
`endif
);

    localparam int unsigned CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [W-1:0]    r_bin;
    logic [4*ND-1:0] r_scr;
    logic [4*ND-1:0] w_scr_adj;
    logic [CW-1:0]   r_cnt;
    logic            r_done;
    logic [4*ND-1:0] r_bcd;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_SHIFT;
            S_SHIFT: if (r_cnt == CW'(1)) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Per-digit add-3 correction; digits are independent, no carry between them.
    always_comb begin
        w_scr_adj = '0;
        for (int unsigned d = 0; d < ND; d++) begin
            if (r_scr[4*d +: 4] >= 4'd5)
                w_scr_adj[4*d +: 4] = r_scr[4*d +: 4] + 4'd3;
            else
                w_scr_adj[4*d +: 4] = r_scr[4*d +: 4];
        end
    end

`ifdef BIN2BCD_OVF_EN
    logic w_ovf;
    logic r_ovf;

    always_comb begin
        w_ovf = 1'b0;
        for (int unsigned d = 2; d < ND; d++) begin
            if (r_scr[4*d +: 4] != 4'd0) w_ovf = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_ovf <= 1'b0;
        else if (r_state == S_DONE)
            r_ovf <= w_ovf;
    end

    assign ovf = r_ovf;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_bin   <= '0;
            r_scr   <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_bcd   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= (r_state == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_bin <= bin;
                        r_scr <= '0;
                        r_cnt <= CW'(W);
                    end
                end
                S_SHIFT: begin
                    {r_scr, r_bin} <= {w_scr_adj, r_bin} << 1;
                    r_cnt          <= r_cnt - CW'(1);
                end
                S_DONE: begin
                    r_bcd <= r_scr;
                end
                default: ;
            endcase
        end
    end

    // done is registered out of DONE, so busy spans it to cover the pulse cycle.
    assign busy = (r_state != S_IDLE) || r_done;
    assign done = r_done;
    assign bcd  = r_bcd;

endmodule
